// File: rtl/spm_ctrl.sv
// Sequencer for an 8x8 signed serial-parallel multiplier core.
// Latches the operands and clears the core. It then streams the multiplier LSB first
// for 16 cycles with sign extension, and gathers the serial product into a 16-bit result.
module spm_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        start,
  input  logic [7:0]  multiplicand,
  input  logic [7:0]  multiplier,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        core_clr,
  output logic        core_en,
  output logic [7:0]  core_x,
  output logic        core_y,
  input  logic        core_p
);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StDone
  } state_e;

  state_e      r_state;
  logic [3:0]  r_cnt;
  logic [7:0]  r_sr;
  logic [15:0] r_acc;
  logic [15:0] r_product;
  logic [7:0]  r_core_x;
  logic        r_busy;
  logic        r_done;
  logic        r_core_clr;
  logic        r_core_en;

  logic [15:0] w_acc_next;
  logic [7:0]  w_sr_next;

  // Product bits arrive LSB first, so each new bit enters at the top and older bits
  // move down. After 16 shifts, bit 0 sits at acc[0].
  assign w_acc_next = {core_p, r_acc[15:1]};
  // An arithmetic shift keeps the sign bit, which sign-extends the multiplier in cycles 8..15.
  assign w_sr_next  = {r_sr[7], r_sr[7:1]};

  // Control FSM with registered outputs. clr overrides everything except reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_cnt      <= 4'd0;
      r_sr       <= 8'd0;
      r_acc      <= 16'd0;
      r_product  <= 16'd0;
      r_core_x   <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_core_clr <= 1'b0;
      r_core_en  <= 1'b0;
    end else if (clr) begin
      r_state    <= StIdle;
      r_cnt      <= 4'd0;
      r_acc      <= 16'd0;
      r_product  <= 16'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_core_clr <= 1'b0;
      r_core_en  <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          r_done     <= 1'b0;
          r_core_clr <= 1'b0;
          r_core_en  <= 1'b0;
          if (start) begin
            r_core_x   <= multiplicand;
            r_sr       <= multiplier;
            r_core_clr <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StClear;
          end
        end
        StClear: begin
          r_core_clr <= 1'b0;
          r_core_en  <= 1'b1;
          r_cnt      <= 4'd0;
          r_acc      <= 16'd0;
          r_state    <= StRun;
        end
        StRun: begin
          r_sr  <= w_sr_next;
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            // The final bit is still on core_p, so take the result from the next-state value.
            r_product <= w_acc_next;
            r_core_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= StDone;
          end
        end
        StDone: begin
          r_done  <= 1'b0;
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign product  = r_product;
  assign core_clr = r_core_clr;
  assign core_en  = r_core_en;
  assign core_x   = r_core_x;
  // The serial bit is gated by the enable, so the core sees 0 outside RUN.
  assign core_y   = r_core_en & r_sr[0];

endmodule

// File: tb/tb_spm_ctrl.sv
// Directed bench for spm_ctrl, driven by a behavioural serial multiplier core.
module tb_spm_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        core_clr;
  logic        core_en;
  logic [7:0]  core_x;
  logic        core_y;
  logic        core_p;

  int          n_chk  = 0;
  int          n_pass = 0;

  // The core model works from the bench's own copy of the operands.
  logic [15:0] m_prod = 16'd0;
  int          m_k    = 0;

  always #5 clk = ~clk;

  spm_ctrl u_dut (
    .clk          (clk),
    .rst          (rst),
    .clr          (clr),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .core_clr     (core_clr),
    .core_en      (core_en),
    .core_x       (core_x),
    .core_y       (core_y),
    .core_p       (core_p)
  );

  // Track the RUN cycle index the way a real core would: it is cleared by core_clr
  // and advanced by core_en.
  always @(posedge clk) begin
    if (core_clr)     m_k <= 0;
    else if (core_en) m_k <= m_k + 1;
  end

  assign core_p = (m_k < 16) ? m_prod[m_k[3:0]] : 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic set_ops(input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    m_prod       = p;
    multiplicand = a;
    multiplier   = b;
  endtask

  // Call this at a negedge. It starts a multiply and then watches 40 cycles.
  // If inj is nonzero, a second start with other operands is pulsed at that cycle.
  task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] ep, input logic [15:0] ey, input int inj);
    int          done_cyc;
    int          ndone;
    int          nclr;
    logic [15:0] y;
    done_cyc = 0;
    ndone    = 0;
    nclr     = 0;
    y        = 16'd0;
    set_ops(a, b);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        done_cyc = c;
      end
      if (core_clr) nclr++;
      if (c >= 2 && c <= 17) y[c-2] = core_y;
      if (c == 1)  check_eq({nm, ".clear"}, {29'd0, core_clr, busy, core_en}, 32'b110);
      if (c == 2)  check_eq({nm, ".core_x"}, {24'd0, core_x}, {24'd0, a});
      if (c == 17) check_eq({nm, ".run_last"}, {30'd0, busy, core_en}, 32'b11);
      if (c == 18) begin
        check_eq({nm, ".prod_done"}, {16'd0, product}, {16'd0, ep});
        check_eq({nm, ".idle_flags"}, {30'd0, busy, core_en}, 32'd0);
      end
      if (c == inj) begin
        start        = 1'b1;
        multiplicand = 8'd9;
        multiplier   = 8'd9;
      end else begin
        start = 1'b0;
      end
    end
    check_eq({nm, ".done_cycle"}, done_cyc, 18);
    check_eq({nm, ".done_count"}, ndone, 1);
    check_eq({nm, ".clr_count"}, nclr, 1);
    check_eq({nm, ".core_y"}, {16'd0, y}, {16'd0, ey});
    check_eq({nm, ".prod_hold"}, {16'd0, product}, {16'd0, ep});
  endtask

  // Call this at a negedge. It counts done pulses and busy cycles over n cycles.
  task automatic quiet(input string nm, input int n);
    int nd;
    int nb;
    nd = 0;
    nb = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (done) nd++;
      if (busy) nb++;
    end
    check_eq({nm, ".no_done"}, nd, 0);
    check_eq({nm, ".no_busy"}, nb, 0);
  endtask

  initial begin
    rst          = 1'b0;
    clr          = 1'b0;
    start        = 1'b0;
    multiplicand = 8'd0;
    multiplier   = 8'd0;
    #12;
    check_eq("reset.flags", {27'd0, busy, done, core_clr, core_en, core_y}, 32'd0);
    check_eq("reset.product", {16'd0, product}, 32'd0);
    check_eq("reset.core_x", {24'd0, core_x}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // clr takes priority over start while in IDLE.
    set_ops(8'd5, 8'd3);
    start = 1'b1;
    clr   = 1'b1;
    @(negedge clk);
    check_eq("clr_prio.busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    clr   = 1'b0;
    @(negedge clk);

    run_op("m5x3", 8'd5, 8'd3, 16'h000F, 16'h0003, 0);
    run_op("mneg3x7", 8'hFD, 8'd7, 16'hFFEB, 16'h0007, 0);
    run_op("m128x128", 8'h80, 8'h80, 16'h4000, 16'hFF80, 0);
    // Cycle 7 is RUN cycle 5.
    run_op("ignore_start", 8'd6, 8'hFE, 16'hFFF4, 16'hFFFE, 7);

    // Abort with clr in RUN cycle 3, after a 0x000F result.
    run_op("pre_clr", 8'd5, 8'd3, 16'h000F, 16'h0003, 0);
    set_ops(8'd7, 8'd7);
    start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_eq("clr.product", {16'd0, product}, 32'd0);
    check_eq("clr.flags", {29'd0, busy, core_en, done}, 32'd0);
    quiet("clr", 25);

    // Asynchronous reset in RUN cycle 9 (cycle 11).
    set_ops(8'd5, 8'd3);
    start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b0;
    #1;
    check_eq("arst.flags", {27'd0, busy, done, core_clr, core_en, core_y}, 32'd0);
    check_eq("arst.product", {16'd0, product}, 32'd0);
    check_eq("arst.core_x", {24'd0, core_x}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    quiet("arst", 25);
    run_op("m2x2", 8'd2, 8'd2, 16'h0004, 16'h0002, 0);

    // The first edge after reset release must accept start.
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op("post_rst", 8'h7F, 8'h7F, 16'h3F01, 16'h007F, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
